fpu_operand_loader: RTL and testbench

Front-end companion of the FPU control FSM. It turns a user button and a 16-bit switch word into the one-cycle `start` pulses the FSM consumes. It captures and unpacks the operands and opcode into the 18-bit working format the FSM reads, and holds the result register the FSM writes and then evaluates. It also latches the done/error status for display until the next operation begins.

---
 rtl/fpu_operand_loader.sv | 129 ++++++++++++
 tb/tb_fpu_operand_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_operand_loader.sv
// fpu_operand_loader: front end of the FPU control FSM.
// It turns a debounced button press into a one-cycle start pulse. It captures
// and unpacks half-precision operands into the FSM's 18-bit working format.
// It holds the opcode and the result register. It latches done/error status
// for display until the next operation starts.
//
// Handshake: this block has no valid/ready pair. The FSM owns all sequencing.
// - start_q is a one-cycle step request to the FSM.
// - Each ena* input is a level-sensitive capture enable, sampled every cycle.
// - ready/error are one-cycle pulses from the FSM that set the sticky flags.
module fpu_operand_loader #(
    parameter int HOLDOFF = 1000,
    parameter int CNT_W   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic [15:0] din,
    input  logic        enaA,
    input  logic        enaB,
    input  logic        enaO,
    input  logic        enaR,
    input  logic [15:0] result,
    input  logic        ready,
    input  logic        error,
    output logic        start,
    output logic [17:0] A,
    output logic [17:0] B,
    output logic [1:0]  O,
    output logic [15:0] R,
    output logic        done,
    output logic        err
);

    // Working format: {sign, exp[4:0], guard=0, hidden, mant[9:0]}.
    // The hidden bit is 0 for zero and subnormal inputs.
    function automatic logic [17:0] unpack(input logic [15:0] d);
        unpack = {d[15], d[14:10], 1'b0, (d[14:10] != 5'd0), d[9:0]};
    endfunction

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q,  prev_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             start_q, start_d;
    logic [17:0]      a_q,     a_d;
    logic [17:0]      b_q,     b_d;
    logic [1:0]       o_q,     o_d;
    logic [15:0]      r_q,     r_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;
    logic             btn_rise;
    logic             fire;

    // Next-state logic for the button path, the capture registers and the flags.
    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        btn_rise = sync2_q & ~prev_q;
        // Edges during holdoff are dropped, not queued.
        fire     = btn_rise && (cnt_q == '0);
        start_d  = fire;

        cnt_d = cnt_q;
        if (fire) begin
            cnt_d = CNT_W'(HOLDOFF);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        a_d = a_q;
        b_d = b_q;
        o_d = o_q;
        r_d = r_q;
        if (enaA) a_d = unpack(din);
        if (enaB) b_d = unpack(din);
        if (enaO) o_d = din[1:0];
        if (enaR) r_d = result;

        // The flags clear while start is out. A set in the same cycle wins.
        done_d = done_q;
        err_d  = err_q;
        if (start_q) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (ready) done_d = 1'b1;
        if (error) err_d  = 1'b1;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            o_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            o_q     <= o_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign start = start_q;
    assign A     = a_q;
    assign B     = b_q;
    assign O     = o_q;
    assign R     = r_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed bench for fpu_operand_loader with a short holdoff.
module tb_fpu_operand_loader;

    localparam int HOLDOFF = 4;
    localparam int CNT_W   = 3;

    logic        clk;
    logic        rst;
    logic        btn;
    logic [15:0] din;
    logic        enaA, enaB, enaO, enaR;
    logic [15:0] result;
    logic        ready, error;
    logic        start;
    logic [17:0] A, B;
    logic [1:0]  O;
    logic [15:0] R;
    logic        done, err;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_operand_loader #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .btn(btn), .din(din),
        .enaA(enaA), .enaB(enaB), .enaO(enaO), .enaR(enaR),
        .result(result), .ready(ready), .error(error),
        .start(start), .A(A), .B(B), .O(O), .R(R),
        .done(done), .err(err)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for the start pulse. On return, the current cycle is the one with start=1.
    task automatic wait_start(input string tag, input int max_cyc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            tick();
            if (start) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    // Press the button and act as the FSM for one step.
    task automatic press_and_load(input string tag, input logic la, input logic lb,
                                  input logic lo, input logic [15:0] d);
        btn = 1'b1;
        wait_start(tag, 8);
        enaA = la; enaB = lb; enaO = lo; din = d;
        tick();
        enaA = 1'b0; enaB = 1'b0; enaO = 1'b0;
        btn  = 1'b0;
        ticks(HOLDOFF + 3);
    endtask

    int pulse_idx[$];
    int first_p;
    int win_cnt;
    int min_gap;

    initial begin
        rst = 1'b0; btn = 1'b0; din = '0;
        enaA = 1'b0; enaB = 1'b0; enaO = 1'b0; enaR = 1'b0;
        result = '0; ready = 1'b0; error = 1'b0;

        // Reset state.
        #2;
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_A", {14'd0, A}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        ticks(2);
        rst = 1'b1;
        ticks(2);

        // Unpack A.
        enaA = 1'b1; din = 16'h3C00; tick();
        check("A_3C00", {14'd0, A}, 32'h0F400);
        din = 16'h0000; tick();
        check("A_0000", {14'd0, A}, 32'h00000);
        din = 16'h7C00; tick();
        check("A_7C00", {14'd0, A}, 32'h1F400);
        din = 16'hBE00; tick();
        check("A_BE00", {14'd0, A}, 32'h2F600);
        enaA = 1'b0; din = 16'hFFFF; ticks(2);
        check("A_hold", {14'd0, A}, 32'h2F600);

        // Unpack B and the opcode.
        enaB = 1'b1; din = 16'h4000; tick(); enaB = 1'b0;
        check("B_4000", {14'd0, B}, 32'h10400);
        check("A_indep", {14'd0, A}, 32'h2F600);
        enaO = 1'b1; din = 16'h0002; tick(); enaO = 1'b0;
        check("O_mul", {30'd0, O}, 32'd2);
        din = 16'h0003; tick();
        check("O_hold", {30'd0, O}, 32'd2);

        // Simultaneous capture of a subnormal value: the hidden bit is 0.
        enaA = 1'b1; enaB = 1'b1; enaO = 1'b1; din = 16'h0001; tick();
        enaA = 1'b0; enaB = 1'b0; enaO = 1'b0;
        check("A_sub", {14'd0, A}, 32'h00001);
        check("B_sub", {14'd0, B}, 32'h00001);
        check("O_sub", {30'd0, O}, 32'd1);

        // Result register and the sticky flags.
        enaR = 1'b1; result = 16'h4200; tick();
        enaR = 1'b0; result = 16'hFFFF; tick();
        check("R_4200", {16'd0, R}, 32'h4200);
        ready = 1'b1; tick(); ready = 1'b0;
        check("done_set", {31'd0, done}, 32'd1);
        ticks(3);
        check("done_held", {31'd0, done}, 32'd1);
        check("err_quiet", {31'd0, err}, 32'd0);
        btn = 1'b1;
        wait_start("start_clr", 8);
        check("done_in_start", {31'd0, done}, 32'd1);
        tick();
        check("done_clr", {31'd0, done}, 32'd0);
        btn = 1'b0;
        ticks(HOLDOFF + 3);
        btn = 1'b1;
        wait_start("start_err", 8);
        error = 1'b1; tick(); error = 1'b0;
        check("err_set_wins", {31'd0, err}, 32'd1);
        btn = 1'b0;
        ticks(3);
        check("err_held", {31'd0, err}, 32'd1);
        ticks(HOLDOFF + 3);

        // Reset in the middle of a holdoff.
        btn = 1'b1;
        ticks(5);
        rst = 1'b0;
        #1;
        check("arst_start", {31'd0, start}, 32'd0);
        check("arst_A", {14'd0, A}, 32'd0);
        check("arst_B", {14'd0, B}, 32'd0);
        check("arst_O", {30'd0, O}, 32'd0);
        check("arst_R", {16'd0, R}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        btn = 1'b0;
        ticks(2);
        rst = 1'b1;
        ticks(2);
        // The counter is cleared by reset, so the press gives start 3 edges later.
        btn = 1'b1;
        tick(); check("lat_e0", {31'd0, start}, 32'd0);
        tick(); check("lat_e1", {31'd0, start}, 32'd0);
        tick(); check("lat_e2", {31'd0, start}, 32'd1);
        tick(); check("lat_width", {31'd0, start}, 32'd0);
        btn = 1'b0;
        ticks(HOLDOFF + 3);

        // Debounce: btn toggles every cycle for 10 cycles.
        // Rising edges are 2 cycles apart. After a pulse, the next HOLDOFF cycles stay quiet.
        for (int i = 0; i < 20; i++) begin
            btn = (i < 10) ? ~i[0] : 1'b0;
            tick();
            if (start) pulse_idx.push_back(i);
        end
        check("deb_any", {31'd0, (pulse_idx.size() > 0)}, 32'd1);
        first_p = (pulse_idx.size() > 0) ? pulse_idx[0] : 0;
        win_cnt = 0;
        foreach (pulse_idx[k]) if (pulse_idx[k] <= first_p + HOLDOFF) win_cnt++;
        check("deb_window", win_cnt, 32'd1);
        min_gap = 1000;
        for (int k = 1; k < pulse_idx.size(); k++)
            if (pulse_idx[k] - pulse_idx[k-1] < min_gap) min_gap = pulse_idx[k] - pulse_idx[k-1];
        check("deb_spacing", {31'd0, (min_gap >= HOLDOFF + 1)}, 32'd1);
        ticks(HOLDOFF + 3);

        // Full operation: 1.0 + 2.0 with opcode add, result 3.0.
        press_and_load("op_A", 1'b1, 1'b0, 1'b0, 16'h3C00);
        press_and_load("op_B", 1'b0, 1'b1, 1'b0, 16'h4000);
        press_and_load("op_O", 1'b0, 1'b0, 1'b1, 16'h0000);
        enaR = 1'b1; result = 16'h4200; tick();
        enaR = 1'b0; result = 16'h0000;
        ready = 1'b1; tick(); ready = 1'b0;
        check("op_A_val", {14'd0, A}, 32'h0F400);
        check("op_B_val", {14'd0, B}, 32'h10400);
        check("op_O_val", {30'd0, O}, 32'd0);
        check("op_R_val", {16'd0, R}, 32'h4200);
        check("op_done", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
